div_arbiter: RTL and testbench
==============================

Name: div_arbiter

Overview:
- Shares one 4-bit restoring divider (Go / ResultValid handshake, operands sampled the cycle after Go, result 6 cycles after that) between N requesters.
- Grants requesters round-robin and holds their operands stable across the divider's load cycle.
- Sequences the divider's Go and owns its synchronous reset.
- Returns quotient/remainder to the granted requester; short-circuits divide-by-zero; recovers from a hung divider via a watchdog.

Parameters:
N, 4, number of requesters (2..8)
TIMEOUT, 15, max cycles waited for divider completion before error

Ports:
Clock  in  1  system clock
Reset  in  1  asynchronous, active-low reset
Req  in  N  per-requester request level; operands valid while high
ReqDividend  in  4*N  dividend, requester i at [4i+3:4i]
ReqDivisor  in  4*N  divisor, packed as ReqDividend
Grant  out  N  one-hot, one-cycle pulse: request accepted, operands captured
RespValid  out  N  one-hot, one-cycle pulse to the owning requester
RespQuotient  out  4  quotient, valid with RespValid
RespRemainder  out  4  remainder, valid with RespValid
RespDivZero  out  1  divisor was 0, valid with RespValid
RespError  out  1  watchdog fired, valid with RespValid
Busy  out  1  high in every state except IDLE
DivReset  out  1  divider reset, active-high synchronous
DivGo  out  1  divider Go
DivDividend  out  4  registered operand to divider
DivDivisor  out  4  registered operand to divider
DivQuotient  in  4  divider result
DivRemainder  in  4  divider result
DivResultValid  in  1  divider done level

Behaviour:
- Reset low (async): state INIT, rr pointer 0, all registers 0, DivReset=1, all other outputs 0.
- States: INIT, IDLE, ISSUE, WAIT_LOW, WAIT_HIGH, RESP, ZRESP.
- INIT: DivReset=1 for exactly one clock, then IDLE. This guarantees the divider sees a clock edge with reset high and sits in its reset-hold state.
- IDLE, arbitration:
  - If any Req bit is high, grant the first set bit at or after rr pointer, wrapping (i = ptr, ptr+1, ..., N-1, 0, ...).
  - Grant[i]=1 combinationally in that cycle. Latch owner id, ReqDividend[i] and ReqDivisor[i] into DivDividend/DivDivisor. Set ptr = (i+1) mod N.
  - Latched divisor==0 -> ZRESP; else -> ISSUE.
  - No Req -> stay in IDLE, Grant=0.
- ISSUE: DivGo=1 for one cycle -> WAIT_LOW.
- WAIT_LOW: waits for DivResultValid=0 (divider entered its load state; stale done level cleared) -> WAIT_HIGH.
- WAIT_HIGH: on DivResultValid=1, capture DivQuotient/DivRemainder -> RESP.
- RESP (one cycle):
  - RespValid[owner]=1; Resp* driven from captured registers; -> IDLE.
  - RespDivZero=0. RespError=0 unless entered via timeout.
- ZRESP (one cycle): RespValid[owner]=1, RespQuotient=4'hF, RespRemainder=latched dividend, RespDivZero=1. The divider is not used. -> IDLE.
- Watchdog:
  - 4-bit counter cleared on entering WAIT_LOW, increments each cycle in WAIT_LOW/WAIT_HIGH.
  - On reaching TIMEOUT: RespValid[owner]=1, RespError=1, Q=R=0 that cycle, then -> INIT, which re-resets the divider.
- DivDividend/DivDivisor are held constant from grant until the next grant.
- Latency:
  - Grant at cycle t -> DivGo t+1 -> divider load t+2 -> DivResultValid t+7 -> RespValid t+8.
  - Next grant no earlier than t+9.
  - Div-by-zero: RespValid at t+1.
- Requester rules:
  - Requesters hold Req and operands until Grant.
  - Req sampled high in the Grant cycle is consumed; keeping Req high afterwards is a new request.
  - Req changes outside IDLE are ignored.
- Simultaneous: Req arriving during RESP/ZRESP is arbitrated in the following IDLE cycle. All requesters high -> strict rotation 0,1,..,N-1,0.
- Reset low mid-operation: abort immediately, no RespValid, -> INIT. The divider is re-reset through DivReset, so no stale result is ever returned.

Decomposition:
- Package div_arb_pkg: state enum (3-bit), DIV_W=4, constant DIV_ZERO_QUOTIENT=4'hF.
- Sub-module rr_arbiter (Req, ptr -> one-hot grant, index): combinational.
- Top div_arbiter holds the FSM, operand/result registers and watchdog. Integration instantiates divider with its reset tied to DivReset.

Test Plan:
- Single request: Req=4'b0001, dividend 13, divisor 4 -> Grant[0] at t, DivGo t+1, RespValid[0] at t+8 with Q=3, R=1, DivZero=0, Error=0.
- All four requesters held high with distinct operands (15/2, 9/3, 7/7, 6/5) -> grants in order 0,1,2,3 spaced 9 cycles; responses Q/R = 7/1, 3/0, 1/0, 1/1 to the matching RespValid bit.
- Divisor 0 from requester 2, dividend 9 -> RespValid[2] at t+1, Q=4'hF, R=9, DivZero=1; DivGo never asserted.
- Hung divider (DivResultValid forced 0) -> RespValid[owner] with RespError=1 after TIMEOUT cycles, then DivReset pulses one cycle and Busy falls.
- Reset low during WAIT_HIGH -> no RespValid; after release DivReset=1 one cycle; next request completes correctly (10/3 -> Q=3, R=1).
- Pointer wrap: ptr=3, Req=4'b1001 -> Grant[3]; re-request both -> Grant[0] next.

Source files
------------

// File: rtl/div_arb_pkg.sv
// Shared types and constants for the divider arbiter.
// Combinational definitions only; the package adds no latency.
// No flow control lives here.
package div_arb_pkg;

    localparam int DIV_W = 4;
    localparam logic [DIV_W-1:0] DIV_ZERO_QUOTIENT = 4'hF;

    // INIT encodes as 0 so that the all-zero reset value is INIT.
    typedef enum logic [2:0] {
        ST_INIT      = 3'd0,
        ST_IDLE      = 3'd1,
        ST_ISSUE     = 3'd2,
        ST_WAIT_LOW  = 3'd3,
        ST_WAIT_HIGH = 3'd4,
        ST_RESP      = 3'd5,
        ST_ZRESP     = 3'd6
    } state_t;

endpackage

// File: rtl/div_arbiter_rr.sv
// Round-robin picker: first set request at or after i_ptr, wrapping modulo N.
// Purely combinational, so a grant appears in the same cycle as its request.
// No backpressure; the caller decides when the grant is consumed.
// Ports: i_req (request levels), i_ptr (search start) ->
//        o_grant (one-hot), o_idx (index of the granted bit), o_any (some request set).
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_grant,
    output logic [IW-1:0] o_idx,
    output logic          o_any
);

    always_comb begin
        int j;
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        j       = 0;
        for (int k = 0; k < N; k++) begin
            j = (int'(i_ptr) + k) % N;
            if (!o_any && i_req[j]) begin
                o_any      = 1'b1;
                o_grant[j] = 1'b1;
                o_idx      = IW'(j);
            end
        end
    end

endmodule

// File: rtl/div_arbiter.sv
// Shares one 4-bit Go/ResultValid divider between N requesters, round-robin.
// Latency: grant t -> DivGo t+1 -> RespValid t+8; divide-by-zero answers at t+1.
// Backpressure: requesters hold Req until Grant; requests outside IDLE are ignored.
// Ports: i_clk, i_rst_n; i_req/i_req_dividend/i_req_divisor from requesters;
//        o_grant, o_resp_* back to them; o_div_* / i_div_* to the shared divider; o_busy.
module div_arbiter
    import div_arb_pkg::*;
#(
    parameter int N       = 4,
    parameter int TIMEOUT = 15
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [N-1:0]       i_req,
    input  logic [DIV_W*N-1:0] i_req_dividend,
    input  logic [DIV_W*N-1:0] i_req_divisor,
    output logic [N-1:0]       o_grant,
    output logic [N-1:0]       o_resp_valid,
    output logic [DIV_W-1:0]   o_resp_quotient,
    output logic [DIV_W-1:0]   o_resp_remainder,
    output logic               o_resp_div_zero,
    output logic               o_resp_error,
    output logic               o_busy,
    output logic               o_div_reset,
    output logic               o_div_go,
    output logic [DIV_W-1:0]   o_div_dividend,
    output logic [DIV_W-1:0]   o_div_divisor,
    input  logic [DIV_W-1:0]   i_div_quotient,
    input  logic [DIV_W-1:0]   i_div_remainder,
    input  logic               i_div_result_valid
);

    localparam int IW = $clog2(N);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [IW-1:0]    r_ptr;
    logic [IW-1:0]    r_owner;
    logic [3:0]       r_wdog;
    logic [DIV_W-1:0] r_dvd;
    logic [DIV_W-1:0] r_dvs;
    logic [DIV_W-1:0] r_quo;
    logic [DIV_W-1:0] r_rem;

    logic [N-1:0]     w_arb_grant;
    logic [IW-1:0]    w_idx;
    logic             w_any;
    logic [IW-1:0]    w_ptr_nxt;
    logic [DIV_W-1:0] w_sel_dvd;
    logic [DIV_W-1:0] w_sel_dvs;
    logic [N-1:0]     w_owner_1h;
    logic             w_timeout;
    logic             w_accept;

    rr_arbiter #(.N(N), .IW(IW)) u_rr (
        .i_req   (i_req),
        .i_ptr   (r_ptr),
        .o_grant (w_arb_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    assign w_sel_dvd  = i_req_dividend[w_idx*DIV_W +: DIV_W];
    assign w_sel_dvs  = i_req_divisor[w_idx*DIV_W +: DIV_W];
    assign w_ptr_nxt  = (w_idx == IW'(N-1)) ? '0 : w_idx + 1'b1;
    assign w_owner_1h = N'(1) << r_owner;
    assign w_timeout  = (r_wdog == 4'(TIMEOUT));
    assign w_accept   = (r_state == ST_IDLE) && w_any;

    assign o_div_dividend = r_dvd;
    assign o_div_divisor  = r_dvs;
    assign o_busy         = (r_state != ST_IDLE);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_INIT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        o_grant          = '0;
        o_resp_valid     = '0;
        o_resp_quotient  = '0;
        o_resp_remainder = '0;
        o_resp_div_zero  = 1'b0;
        o_resp_error     = 1'b0;
        o_div_reset      = 1'b0;
        o_div_go         = 1'b0;
        case (r_state)
            ST_INIT: begin
                o_div_reset = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            ST_IDLE: begin
                if (w_any) begin
                    o_grant     = w_arb_grant;
                    w_state_nxt = (w_sel_dvs == '0) ? ST_ZRESP : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                o_div_go    = 1'b1;
                w_state_nxt = ST_WAIT_LOW;
            end
            // A low done level proves the divider left its previous done state.
            ST_WAIT_LOW: begin
                if (w_timeout) begin
                    o_resp_valid = w_owner_1h;
                    o_resp_error = 1'b1;
                    w_state_nxt  = ST_INIT;
                end else if (!i_div_result_valid) begin
                    w_state_nxt = ST_WAIT_HIGH;
                end
            end
            // A result arriving on the timeout cycle still wins over the watchdog.
            ST_WAIT_HIGH: begin
                if (i_div_result_valid) begin
                    w_state_nxt = ST_RESP;
                end else if (w_timeout) begin
                    o_resp_valid = w_owner_1h;
                    o_resp_error = 1'b1;
                    w_state_nxt  = ST_INIT;
                end
            end
            ST_RESP: begin
                o_resp_valid     = w_owner_1h;
                o_resp_quotient  = r_quo;
                o_resp_remainder = r_rem;
                w_state_nxt      = ST_IDLE;
            end
            ST_ZRESP: begin
                o_resp_valid     = w_owner_1h;
                o_resp_quotient  = DIV_ZERO_QUOTIENT;
                o_resp_remainder = r_dvd;
                o_resp_div_zero  = 1'b1;
                w_state_nxt      = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_INIT;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ptr   <= '0;
            r_owner <= '0;
            r_wdog  <= '0;
            r_dvd   <= '0;
            r_dvs   <= '0;
            r_quo   <= '0;
            r_rem   <= '0;
        end else begin
            // Operands stay frozen from one grant to the next, covering the load cycle.
            if (w_accept) begin
                r_owner <= w_idx;
                r_dvd   <= w_sel_dvd;
                r_dvs   <= w_sel_dvs;
                r_ptr   <= w_ptr_nxt;
            end
            if (r_state == ST_ISSUE) begin
                r_wdog <= '0;
            end else if (r_state == ST_WAIT_LOW || r_state == ST_WAIT_HIGH) begin
                r_wdog <= r_wdog + 4'd1;
            end
            if (r_state == ST_WAIT_HIGH && i_div_result_valid) begin
                r_quo <= i_div_quotient;
                r_rem <= i_div_remainder;
            end
        end
    end

endmodule

// File: tb/tb_div_arbiter.sv
module tb_div_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
    logic [15:0] req_dvd;
    logic [15:0] req_dvs;
    logic [3:0]  grant;
    logic [3:0]  resp_valid;
    logic [3:0]  resp_q;
    logic [3:0]  resp_r;
    logic        resp_dz;
    logic        resp_err;
    logic        busy;
    logic        div_reset;
    logic        div_go;
    logic [3:0]  div_dvd;
    logic [3:0]  div_dvs;
    logic [3:0]  div_q;
    logic [3:0]  div_r;
    logic        div_valid;

    int vectors = 0;
    int errors  = 0;

    div_arbiter #(.N(4), .TIMEOUT(15)) dut (
        .i_clk              (clk),
        .i_rst_n            (rst_n),
        .i_req              (req),
        .i_req_dividend     (req_dvd),
        .i_req_divisor      (req_dvs),
        .o_grant            (grant),
        .o_resp_valid       (resp_valid),
        .o_resp_quotient    (resp_q),
        .o_resp_remainder   (resp_r),
        .o_resp_div_zero    (resp_dz),
        .o_resp_error       (resp_err),
        .o_busy             (busy),
        .o_div_reset        (div_reset),
        .o_div_go           (div_go),
        .o_div_dividend     (div_dvd),
        .o_div_divisor      (div_dvs),
        .i_div_quotient     (div_q),
        .i_div_remainder    (div_r),
        .i_div_result_valid (div_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Divider model: Go seen -> load cycle -> 4 busy cycles -> done level held until next Go.
    logic [1:0] d_st;
    logic [1:0] d_cnt;
    logic [3:0] d_a;
    logic [3:0] d_b;
    logic       hang;

    always @(posedge clk) begin
        if (div_reset) begin
            d_st  <= 2'd0;
            d_cnt <= 2'd0;
            div_q <= 4'd0;
            div_r <= 4'd0;
        end else if (div_go) begin
            d_st <= 2'd1;
        end else begin
            case (d_st)
                2'd1: begin
                    d_a   <= div_dvd;
                    d_b   <= div_dvs;
                    d_cnt <= 2'd0;
                    d_st  <= 2'd2;
                end
                2'd2: begin
                    if (d_cnt == 2'd3) begin
                        d_st  <= 2'd3;
                        div_q <= (d_b == 4'd0) ? 4'hF : d_a / d_b;
                        div_r <= (d_b == 4'd0) ? d_a : d_a % d_b;
                    end else begin
                        d_cnt <= d_cnt + 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign div_valid = (d_st == 2'd3) && !hang;

    task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Move to just after the next n rising edges (input drive point).
    task automatic adv(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic neg();
        @(negedge clk);
    endtask

    logic [3:0] exp_q [4];
    logic [3:0] exp_r [4];

    initial begin
        rst_n   = 1'b0;
        req     = 4'b0;
        req_dvd = 16'h0;
        req_dvs = 16'h0;
        hang    = 1'b0;
        exp_q   = '{4'd7, 4'd3, 4'd1, 4'd1};
        exp_r   = '{4'd1, 4'd0, 4'd0, 4'd1};

        // Reset state
        adv(2);
        neg();
        chk1("rst div_reset", div_reset, 1'b1);
        chk4("rst grant", grant, 4'b0000);
        chk4("rst resp_valid", resp_valid, 4'b0000);
        chk1("rst div_go", div_go, 1'b0);
        chk4("rst div_dividend", div_dvd, 4'd0);
        chk4("rst div_divisor", div_dvs, 4'd0);
        adv(1);
        rst_n = 1'b1;
        neg();
        chk1("init div_reset", div_reset, 1'b1);
        adv(1);
        neg();
        chk1("idle div_reset", div_reset, 1'b0);
        chk1("idle busy", busy, 1'b0);

        // All four requesters held high: strict rotation 0,1,2,3, nine cycles apart
        adv(1);
        req     = 4'b1111;
        req_dvd = {4'd6, 4'd7, 4'd9, 4'd15};
        req_dvs = {4'd5, 4'd7, 4'd3, 4'd2};
        for (int k = 0; k < 4; k++) begin
            neg();
            chk4("rot grant", grant, 4'(1 << k));
            if (k == 3) begin
                adv(1);
                req = 4'b0;
                adv(7);
            end else begin
                adv(8);
            end
            neg();
            chk4("rot resp_valid", resp_valid, 4'(1 << k));
            chk4("rot quotient", resp_q, exp_q[k]);
            chk4("rot remainder", resp_r, exp_r[k]);
            chk1("rot div_zero", resp_dz, 1'b0);
            if (k < 3) adv(1);
        end

        // Single request 13/4 from requester 0
        adv(1);
        req     = 4'b0001;
        req_dvd = 16'h000D;
        req_dvs = 16'h0004;
        neg();
        chk4("single grant", grant, 4'b0001);
        adv(1);
        req = 4'b0;
        neg();
        chk1("single div_go", div_go, 1'b1);
        chk4("single div_dividend", div_dvd, 4'd13);
        chk4("single div_divisor", div_dvs, 4'd4);
        adv(1);
        neg();
        chk1("single go pulse", div_go, 1'b0);
        adv(5);
        neg();
        chk4("single early resp", resp_valid, 4'b0000);
        adv(1);
        neg();
        chk4("single resp_valid", resp_valid, 4'b0001);
        chk4("single quotient", resp_q, 4'd3);
        chk4("single remainder", resp_r, 4'd1);
        chk1("single div_zero", resp_dz, 1'b0);
        chk1("single error", resp_err, 1'b0);
        adv(1);
        neg();
        chk1("single busy after", busy, 1'b0);

        // Divide by zero from requester 2 (pointer is at 1)
        adv(1);
        req     = 4'b0100;
        req_dvd = 16'h0900;
        req_dvs = 16'h0000;
        neg();
        chk4("dz grant", grant, 4'b0100);
        adv(1);
        req = 4'b0;
        neg();
        chk4("dz resp_valid", resp_valid, 4'b0100);
        chk4("dz quotient", resp_q, 4'hF);
        chk4("dz remainder", resp_r, 4'd9);
        chk1("dz div_zero", resp_dz, 1'b1);
        chk1("dz div_go", div_go, 1'b0);
        adv(1);
        neg();
        chk1("dz div_go idle", div_go, 1'b0);
        chk1("dz busy", busy, 1'b0);

        // Pointer wrap: ptr=3, requesters 3 and 0 both held
        adv(1);
        req     = 4'b1001;
        req_dvd = 16'hC008;
        req_dvs = 16'h5002;
        neg();
        chk4("wrap grant3", grant, 4'b1000);
        adv(8);
        neg();
        chk4("wrap resp3 valid", resp_valid, 4'b1000);
        chk4("wrap resp3 q", resp_q, 4'd2);
        chk4("wrap resp3 r", resp_r, 4'd2);
        adv(1);
        neg();
        chk4("wrap grant0", grant, 4'b0001);
        adv(1);
        req = 4'b0;
        adv(7);
        neg();
        chk4("wrap resp0 valid", resp_valid, 4'b0001);
        chk4("wrap resp0 q", resp_q, 4'd4);
        chk4("wrap resp0 r", resp_r, 4'd0);

        // Hung divider: requester 1 (ptr is 1), watchdog fires 17 cycles after grant
        adv(1);
        hang    = 1'b1;
        req     = 4'b0010;
        req_dvd = 16'h0050;
        req_dvs = 16'h0010;
        neg();
        chk4("hang grant", grant, 4'b0010);
        adv(1);
        req = 4'b0;
        adv(15);
        neg();
        chk4("hang early resp", resp_valid, 4'b0000);
        adv(1);
        neg();
        chk4("hang resp_valid", resp_valid, 4'b0010);
        chk1("hang error", resp_err, 1'b1);
        chk4("hang quotient", resp_q, 4'd0);
        chk4("hang remainder", resp_r, 4'd0);
        adv(1);
        neg();
        chk1("hang div_reset", div_reset, 1'b1);
        chk1("hang busy init", busy, 1'b1);
        chk4("hang no repeat", resp_valid, 4'b0000);
        adv(1);
        neg();
        chk1("hang div_reset end", div_reset, 1'b0);
        chk1("hang busy falls", busy, 1'b0);
        hang = 1'b0;

        // Reset during WAIT_HIGH: requester 2 (ptr is 2), then fresh 10/3 from requester 0
        adv(1);
        req     = 4'b0100;
        req_dvd = 16'h0A00;
        req_dvs = 16'h0300;
        neg();
        chk4("abort grant", grant, 4'b0100);
        adv(1);
        req = 4'b0;
        adv(3);
        rst_n = 1'b0;
        neg();
        chk4("abort resp_valid", resp_valid, 4'b0000);
        chk1("abort div_reset", div_reset, 1'b1);
        adv(4);
        neg();
        chk4("abort no late resp", resp_valid, 4'b0000);
        adv(1);
        rst_n = 1'b1;
        neg();
        chk1("abort init div_reset", div_reset, 1'b1);
        chk4("abort init resp", resp_valid, 4'b0000);
        adv(1);
        req     = 4'b0001;
        req_dvd = 16'h000A;
        req_dvs = 16'h0003;
        neg();
        chk1("post div_reset", div_reset, 1'b0);
        chk4("post grant", grant, 4'b0001);
        adv(1);
        req = 4'b0;
        adv(7);
        neg();
        chk4("post resp_valid", resp_valid, 4'b0001);
        chk4("post quotient", resp_q, 4'd3);
        chk4("post remainder", resp_r, 4'd1);
        chk1("post error", resp_err, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
